// File: rtl/arb_bus_mux_if.sv
// Bundle of master-side request/response, arbiter handshake and slave-side bus signals for arb_bus_mux.
// The "slave" modport is the mux's view; "master" is the view of the environment around it.
interface arb_bus_mux_if #(
  parameter int PORTS      = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  localparam int SEL_WIDTH = $clog2(PORTS);

  // core-facing request/response ports
  logic [PORTS-1:0]            s_req_valid;
  logic [PORTS-1:0]            s_req_ready;
  logic [PORTS*ADDR_WIDTH-1:0] s_req_addr;
  logic [PORTS*DATA_WIDTH-1:0] s_req_wdata;
  logic [PORTS*STRB_WIDTH-1:0] s_req_wstrb;
  logic [PORTS-1:0]            s_req_we;
  logic [PORTS-1:0]            s_rsp_valid;
  logic [DATA_WIDTH-1:0]       s_rsp_rdata;
  logic                        s_rsp_err;

  // arbiter handshake
  logic [PORTS-1:0]            arb_request;
  logic [PORTS-1:0]            arb_acknowledge;
  logic [PORTS-1:0]            arb_grant;
  logic                        arb_grant_valid;
  logic [SEL_WIDTH-1:0]        arb_grant_enc;

  // shared interconnect bus
  logic                        m_req_valid;
  logic                        m_req_ready;
  logic [ADDR_WIDTH-1:0]       m_req_addr;
  logic [DATA_WIDTH-1:0]       m_req_wdata;
  logic [STRB_WIDTH-1:0]       m_req_wstrb;
  logic                        m_req_we;
  logic                        m_rsp_valid;
  logic [DATA_WIDTH-1:0]       m_rsp_rdata;
  logic                        m_rsp_err;

  modport slave (
    input  s_req_valid, s_req_addr, s_req_wdata, s_req_wstrb, s_req_we,
    output s_req_ready, s_rsp_valid, s_rsp_rdata, s_rsp_err,
    output arb_request, arb_acknowledge,
    input  arb_grant, arb_grant_valid, arb_grant_enc,
    output m_req_valid, m_req_addr, m_req_wdata, m_req_wstrb, m_req_we,
    input  m_req_ready, m_rsp_valid, m_rsp_rdata, m_rsp_err
  );

  modport master (
    output s_req_valid, s_req_addr, s_req_wdata, s_req_wstrb, s_req_we,
    input  s_req_ready, s_rsp_valid, s_rsp_rdata, s_rsp_err,
    input  arb_request, arb_acknowledge,
    output arb_grant, arb_grant_valid, arb_grant_enc,
    input  m_req_valid, m_req_addr, m_req_wdata, m_req_wstrb, m_req_we,
    output m_req_ready, m_rsp_valid, m_rsp_rdata, m_rsp_err
  );
endinterface

// File: rtl/arb_bus_mux.sv
// Routes the arbiter-granted master onto one slave bus, returns its response, then acknowledges the grant.
// Grant at T -> m_req_valid T+1; with immediate ready and next-cycle response, s_rsp_valid at T+3.
module arb_bus_mux #(
  parameter int PORTS      = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 255
) (
  input logic          clk,
  input logic          rst,
  arb_bus_mux_if.slave bus
);
  localparam int SEL_WIDTH = $clog2(PORTS);
  localparam int CNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_WIDTH'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SEL_WIDTH-1:0]   sel_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [STRB_WIDTH-1:0]  wstrb_q;
  logic                   we_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   err_q;
  logic [CNT_WIDTH-1:0]   cnt_q;

  logic [PORTS-1:0]       req_ready;
  logic [PORTS-1:0]       ack;
  logic [PORTS-1:0]       rsp_valid;
  logic                   take;
  logic                   timeout_hit;
  logic                   gnt_req_valid;
  logic [ADDR_WIDTH-1:0]  gnt_addr;
  logic [DATA_WIDTH-1:0]  gnt_wdata;
  logic [STRB_WIDTH-1:0]  gnt_wstrb;
  logic                   gnt_we;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // Fields of the port named by grant_enc; the one-hot grant is only used for withdrawn requests.
  always_comb begin
    gnt_req_valid = 1'b0;
    gnt_addr      = '0;
    gnt_wdata     = '0;
    gnt_wstrb     = '0;
    gnt_we        = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (bus.arb_grant_enc == SEL_WIDTH'(i)) begin
        gnt_req_valid = bus.s_req_valid[i];
        gnt_addr      = bus.s_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        gnt_wdata     = bus.s_req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        gnt_wstrb     = bus.s_req_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
        gnt_we        = bus.s_req_we[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    ack       = '0;
    rsp_valid = '0;
    take      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.arb_grant_valid) begin
          if (gnt_req_valid) begin
            req_ready[bus.arb_grant_enc] = 1'b1;
            take    = 1'b1;
            state_d = ISSUE;
          end else begin
            // requester dropped before service: release the grant without a bus cycle
            ack = bus.arb_grant;
          end
        end
      end
      ISSUE: begin
        if (bus.m_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.m_rsp_valid || timeout_hit) state_d = DONE;
      end
      DONE: begin
        rsp_valid[sel_q] = 1'b1;
        ack[sel_q]       = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        sel_q   <= bus.arb_grant_enc;
        addr_q  <= gnt_addr;
        wdata_q <= gnt_wdata;
        wstrb_q <= gnt_wstrb;
        we_q    <= gnt_we;
      end
      if (state_q == ISSUE && bus.m_req_ready) cnt_q <= '0;
      if (state_q == WAIT) begin
        if (bus.m_rsp_valid) begin
          rdata_q <= bus.m_rsp_rdata;
          err_q   <= bus.m_rsp_err;
        end else if (timeout_hit) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end else if (cnt_q != '1) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.arb_request     = bus.s_req_valid;
  assign bus.arb_acknowledge = ack;
  assign bus.s_req_ready     = req_ready;
  assign bus.s_rsp_valid     = rsp_valid;
  assign bus.s_rsp_rdata     = rdata_q;
  assign bus.s_rsp_err       = err_q;
  assign bus.m_req_valid     = (state_q == ISSUE);
  assign bus.m_req_addr      = addr_q;
  assign bus.m_req_wdata     = wdata_q;
  assign bus.m_req_wstrb     = wstrb_q;
  assign bus.m_req_we        = we_q;
endmodule

// File: tb/tb_arb_bus_mux.sv
// Bench for arb_bus_mux: round-robin arbiter stand-in, randomizing slave, and a transaction-timeline model.
module tb_arb_bus_mux;
  localparam int PORTS = 2, AW = 32, DW = 32, SW = 4, TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arb_bus_mux_if #(.PORTS(PORTS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) bus ();

  arb_bus_mux #(.PORTS(PORTS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit cmp_en = 0;

  // slave behaviour knobs
  int rdy_pct = 100, dmin = 1, dmax = 1;
  bit no_rsp = 0, noise = 0, use_fix = 0;
  int rsp_at = -1;
  logic [DW-1:0] rsp_fix = '0;

  // transaction timeline model
  bit m_busy = 0, m_issue = 0, m_wait = 0;
  int m_done = -1, m_hs = 0, m_sel = 0;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [SW-1:0] m_wstrb;
  logic m_we, m_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // round-robin arbiter that holds its grant until acknowledged
  int last = PORTS - 1;
  always @(posedge clk) begin : arb
    int pick;
    bit found;
    if (rst) begin
      bus.arb_grant_valid <= 1'b0;
      bus.arb_grant       <= '0;
      bus.arb_grant_enc   <= '0;
      last = PORTS - 1;
    end else if (!bus.arb_grant_valid || (bus.arb_acknowledge & bus.arb_grant) != '0) begin
      found = 0;
      pick  = 0;
      for (int k = 1; k <= PORTS; k++) begin
        if (!found && bus.s_req_valid[(last + k) % PORTS]) begin
          found = 1;
          pick  = (last + k) % PORTS;
        end
      end
      bus.arb_grant_valid <= found;
      bus.arb_grant       <= found ? (PORTS'(1) << pick) : '0;
      bus.arb_grant_enc   <= 1'(pick);
      if (found) last = pick;
    end
  end

  // model: advance the current transaction at the end of each cycle
  always @(posedge clk) begin : model
    if (rst) begin
      m_busy = 0; m_issue = 0; m_wait = 0; m_done = -1; rsp_at = -1;
    end else if (!m_busy) begin
      if (bus.arb_grant_valid && bus.s_req_valid[bus.arb_grant_enc]) begin
        m_busy  = 1; m_issue = 1; m_done = -1;
        m_sel   = int'(bus.arb_grant_enc);
        m_addr  = bus.s_req_addr[m_sel*AW +: AW];
        m_wdata = bus.s_req_wdata[m_sel*DW +: DW];
        m_wstrb = bus.s_req_wstrb[m_sel*SW +: SW];
        m_we    = bus.s_req_we[m_sel];
      end
    end else if (m_issue) begin
      if (bus.m_req_ready) begin
        m_issue = 0; m_wait = 1; m_hs = cyc;
        rsp_at  = no_rsp ? cyc + TO + 2 : cyc + $urandom_range(dmax, dmin);
      end
    end else if (m_wait) begin
      if (bus.m_rsp_valid) begin
        m_rdata = bus.m_rsp_rdata; m_err = bus.m_rsp_err; m_wait = 0; m_done = cyc + 1;
      end else if (TO != 0 && cyc - m_hs == TO) begin
        m_rdata = '0; m_err = 1'b1; m_wait = 0; m_done = cyc + 1;
      end
    end else if (cyc == m_done) begin
      m_busy = 0;
    end
    cyc++;
  end

  // compare process
  always @(negedge clk) begin : cmp
    logic [PORTS-1:0] e_rdy, e_ack, e_rsp;
    if (cmp_en && !rst) begin
      e_rdy = '0; e_ack = '0; e_rsp = '0;
      if (!m_busy && bus.arb_grant_valid) begin
        if (bus.s_req_valid[bus.arb_grant_enc]) e_rdy[bus.arb_grant_enc] = 1'b1;
        else e_ack = bus.arb_grant;
      end
      if (m_busy && cyc == m_done) begin
        e_rsp[m_sel] = 1'b1;
        e_ack = e_rsp;
      end
      chk("arb_request", bus.arb_request, bus.s_req_valid);
      chk("s_req_ready", bus.s_req_ready, e_rdy);
      chk("arb_acknowledge", bus.arb_acknowledge, e_ack);
      chk("s_rsp_valid", bus.s_rsp_valid, e_rsp);
      chk("m_req_valid", bus.m_req_valid, m_busy && m_issue);
      if (m_busy && m_issue) begin
        chk("m_req_addr", bus.m_req_addr, m_addr);
        chk("m_req_wdata", bus.m_req_wdata, m_wdata);
        chk("m_req_wstrb", bus.m_req_wstrb, m_wstrb);
        chk("m_req_we", bus.m_req_we, m_we);
      end
      if (e_rsp != '0) begin
        chk("s_rsp_rdata", bus.s_rsp_rdata, m_rdata);
        chk("s_rsp_err", bus.s_rsp_err, m_err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.m_req_ready = ($urandom_range(0, 99) < rdy_pct);
    bus.m_rsp_valid = (cyc == rsp_at) || (noise && (!m_busy || m_issue) && $urandom_range(0, 3) == 0);
    bus.m_rsp_rdata = (use_fix && cyc == rsp_at) ? rsp_fix : DW'($urandom);
    bus.m_rsp_err   = use_fix ? 1'b0 : ($urandom_range(0, 7) == 0);
  endtask

  task automatic drain();
    bit ok = 0;
    bus.s_req_valid = '0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!m_busy && !bus.arb_grant_valid && rsp_at < cyc) begin
        ok = 1;
        break;
      end
    end
    chk("drain_idle", ok, 1);
  endtask

  task automatic set_req(input int p, input logic [AW-1:0] a, input logic we);
    bus.s_req_valid[p]          = 1'b1;
    bus.s_req_addr[p*AW +: AW]  = a;
    bus.s_req_wdata[p*DW +: DW] = DW'($urandom);
    bus.s_req_wstrb[p*SW +: SW] = 4'hF;
    bus.s_req_we[p]             = we;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_req_ready"}, bus.s_req_ready, 0);
    chk({tag, "_s_rsp_valid"}, bus.s_rsp_valid, 0);
    chk({tag, "_arb_ack"}, bus.arb_acknowledge, 0);
    chk({tag, "_m_req_valid"}, bus.m_req_valid, 0);
    chk({tag, "_m_req_addr"}, bus.m_req_addr, 0);
    chk({tag, "_m_req_wdata"}, bus.m_req_wdata, 0);
    chk({tag, "_m_req_wstrb"}, bus.m_req_wstrb, 0);
    chk({tag, "_m_req_we"}, bus.m_req_we, 0);
    chk({tag, "_s_rsp_rdata"}, bus.s_rsp_rdata, 0);
    chk({tag, "_s_rsp_err"}, bus.s_rsp_err, 0);
  endtask

  logic [PORTS-1:0] pat [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
  int seq [4];
  int n, seen;

  initial begin
    bus.s_req_valid = '0; bus.s_req_addr = '0; bus.s_req_wdata = '0;
    bus.s_req_wstrb = '0; bus.s_req_we = '0;
    bus.m_req_ready = 1'b0; bus.m_rsp_valid = 1'b0; bus.m_rsp_rdata = '0; bus.m_rsp_err = 1'b0;

    // reset, then idle with arb_request following s_req_valid
    repeat (3) tick();
    rst = 0;
    cmp_en = 1;
    @(negedge clk);
    check_reset_outputs("reset");
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.s_req_valid = pat[i];
      @(negedge clk);
      chk("idle_arb_request", bus.arb_request, pat[i]);
    end
    drain();

    // single read from port 0 with immediate slave
    use_fix = 1; rsp_fix = 32'hDEADBEEF;
    tick(); set_req(0, 32'h100, 1'b0);
    tick(); @(negedge clk); chk("rd_s_req_ready", bus.s_req_ready, 2'b01);
    tick(); bus.s_req_valid = '0; @(negedge clk);
    chk("rd_m_req_valid", bus.m_req_valid, 1); chk("rd_m_req_addr", bus.m_req_addr, 32'h100);
    chk("rd_m_req_we", bus.m_req_we, 0);
    tick(); @(negedge clk); chk("rd_wait_no_rsp", bus.s_rsp_valid, 2'b00);
    tick(); @(negedge clk);
    chk("rd_s_rsp_valid", bus.s_rsp_valid, 2'b01); chk("rd_rdata", bus.s_rsp_rdata, 32'hDEADBEEF);
    chk("rd_err", bus.s_rsp_err, 0); chk("rd_ack", bus.arb_acknowledge, 2'b01);
    drain();

    // both ports requesting continuously: served alternately, port 1 first after port 0 was last
    use_fix = 0;
    tick(); set_req(0, 32'h1000, 1'b0); set_req(1, 32'h1004, 1'b1);
    n = 0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      tick();
      @(negedge clk);
      if (bus.s_req_ready == 2'b01) begin seq[n] = 0; n++; end
      else if (bus.s_req_ready == 2'b10) begin seq[n] = 1; n++; end
    end
    chk("rr_count", n, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_port%0d", i), seq[i], (i % 2 == 0) ? 1 : 0);
    drain();

    // slave stalls for 5 cycles while the request stays asserted
    tick(); set_req(1, 32'hABC0, 1'b1);
    rdy_pct = 0;
    tick(); @(negedge clk); chk("stall_accept", bus.s_req_ready, 2'b10);
    for (int k = 0; k < 5; k++) begin
      tick(); @(negedge clk);
      chk("stall_m_req_valid", bus.m_req_valid, 1); chk("stall_addr", bus.m_req_addr, 32'hABC0);
      chk("stall_we", bus.m_req_we, 1); chk("stall_no_ready", bus.s_req_ready, 2'b00);
    end
    rdy_pct = 100;
    tick(); bus.s_req_valid = '0;
    drain();

    // no response: timeout after 4 WAIT cycles, late response dropped
    no_rsp = 1;
    tick(); set_req(0, 32'h200, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 2) bus.s_req_valid = '0;
      @(negedge clk);
      if (k == 7) begin
        chk("to_rsp_valid", bus.s_rsp_valid, 2'b01); chk("to_rdata", bus.s_rsp_rdata, 0);
        chk("to_err", bus.s_rsp_err, 1); chk("to_ack", bus.arb_acknowledge, 2'b01);
      end
      if (k >= 8) chk("to_late_ignored", bus.s_rsp_valid, 2'b00);
    end
    drain();

    // reset during WAIT abandons the transaction; next request is served
    tick(); set_req(1, 32'h5A0, 1'b1);
    tick();
    tick(); bus.s_req_valid = '0;
    tick();
    tick(); rst = 1;
    tick(); rst = 0; @(negedge clk);
    check_reset_outputs("midrst");
    no_rsp = 0; dmin = 2; dmax = 2;
    tick(); set_req(0, 32'h300, 1'b0);
    seen = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 2) bus.s_req_valid = '0;
      @(negedge clk);
      if (bus.s_rsp_valid == 2'b01) seen++;
    end
    chk("post_rst_served", seen, 1);
    drain();

    // randomized traffic
    rdy_pct = 70; dmin = 1; dmax = 6; noise = 1;
    for (int i = 0; i < 2500; i++) begin
      tick();
      rst = ($urandom_range(0, 399) == 0);
      for (int p = 0; p < PORTS; p++) bus.s_req_valid[p] = ($urandom_range(0, 9) < 7);
      bus.s_req_addr  = {$urandom, $urandom};
      bus.s_req_wdata = {$urandom, $urandom};
      bus.s_req_wstrb = 8'($urandom);
      bus.s_req_we    = 2'($urandom);
      no_rsp = ($urandom_range(0, 7) == 0);
    end
    rst = 0; noise = 0; no_rsp = 0; rdy_pct = 100;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
